// File: rtl/spi_pkg.sv
// Shared definitions for the SPI serial-clock engine: operating modes, FSM states
// and the divisor-width helper.
package spi_pkg;

   localparam logic [1:0] SPI_RUN  = 2'b00;
   localparam logic [1:0] SPI_WAIT = 2'b01;
   localparam logic [1:0] SPI_STOP = 2'b10;

   typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} spi_state_e;

   // Width of (pre+1) << (sel+1) for the largest field values.
   function automatic int brd_width(input int pre_w, input int sel_w);
      return pre_w + 1 + (1 << sel_w);
   endfunction

endpackage

// File: rtl/spi_tick_counter.sv
// Half-period timer: counts 0..H-1 with H = (sppr+1) << spr and pulses tick on the
// last count. Holds while en is low; clear forces the count back to zero.
module spi_tick_counter
   import spi_pkg::*;
#(
   parameter int PRE_W = 3,
   parameter int SEL_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clear,
   input  logic [PRE_W-1:0] sppr,
   input  logic [SEL_W-1:0] spr,
   output logic             tick
);

   localparam int CNT_W = brd_width(PRE_W, SEL_W) - 1;

   logic [CNT_W-1:0] half;
   logic [CNT_W-1:0] cnt;

   assign half = (CNT_W'(sppr) + CNT_W'(1)) << spr;
   assign tick = en && !clear && (cnt == half - CNT_W'(1));

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/spi_sclk_engine.sv
// SPI serial-clock engine: baud divisor, SCLK generation in all CPOL/CPHA modes and
// sequencing of one transfer with setup half-period, freeze/resume and abort.
module spi_sclk_engine
   import spi_pkg::*;
#(
   parameter int PRE_W    = 3,
   parameter int SEL_W    = 3,
   parameter int MAX_BITS = 8,
   parameter int LEN_W    = $clog2(MAX_BITS) + 1,
   parameter int BRD_W    = PRE_W + 1 + 2**SEL_W
) (
   input  logic             pclk,
   input  logic             preset_n,
   input  logic [1:0]       spi_mode_i,
   input  logic             spiswai_i,
   input  logic [PRE_W-1:0] sppr_i,
   input  logic [SEL_W-1:0] spr_i,
   input  logic             cpol_i,
   input  logic             cpha_i,
   input  logic             ss_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic             start_i,
   output logic             sclk_o,
   output logic             sample_o,
   output logic             shift_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [BRD_W-1:0] brd_o
);

   localparam int ECW = $clog2(2 * MAX_BITS) + 1;

   spi_state_e       state;
   logic [PRE_W-1:0] sppr_q;
   logic [SEL_W-1:0] spr_q;
   logic             cpol_q;
   logic             cpha_q;
   logic [LEN_W-1:0] bits_q;
   logic [ECW-1:0]   edge_cnt;
   logic [ECW-1:0]   last_edge;
   logic [LEN_W-1:0] len_eff;
   logic             en;
   logic             active;
   logic             clear;
   logic             tick;
   logic             ev;

   assign en        = (spi_mode_i == SPI_RUN) || (spi_mode_i == SPI_WAIT && !spiswai_i);
   assign active    = (state == SETUP) || (state == RUN);
   assign clear     = !active || ss_i;
   assign len_eff   = (len_i == '0 || len_i > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : len_i;
   assign last_edge = ECW'({bits_q, 1'b0}) - ECW'(1);

   spi_tick_counter #(.PRE_W(PRE_W), .SEL_W(SEL_W)) u_tick (
      .clk   (pclk),
      .rst_n (preset_n),
      .en    (en),
      .clear (clear),
      .sppr  (sppr_q),
      .spr   (spr_q),
      .tick  (tick)
   );

   // Strobes mark the cycle before SCLK moves; edge_cnt holds k-1 for the coming edge.
   assign ev       = (state == RUN) && tick;
   assign sample_o = ev && (edge_cnt[0] == cpha_q);
   assign shift_o  = ev && (edge_cnt[0] != cpha_q) && !(!cpha_q && edge_cnt == last_edge);

   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         brd_o <= '0;
      end else begin
         brd_o <= ((BRD_W'(sppr_i) + BRD_W'(1)) << spr_i) << 1;
      end
   end

   // Handshake: start_i is a one-cycle request honoured only in IDLE with ss_i low;
   // busy_o stays high through the single done_o cycle, releasing ss_i aborts silently.
   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         state    <= IDLE;
         sclk_o   <= 1'b0;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
         edge_cnt <= '0;
         sppr_q   <= '0;
         spr_q    <= '0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         bits_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               sclk_o   <= cpol_i;
               busy_o   <= 1'b0;
               done_o   <= 1'b0;
               edge_cnt <= '0;
               if (start_i && !ss_i) begin
                  state  <= SETUP;
                  busy_o <= 1'b1;
                  sppr_q <= sppr_i;
                  spr_q  <= spr_i;
                  cpol_q <= cpol_i;
                  cpha_q <= cpha_i;
                  bits_q <= len_eff;
               end
            end
            SETUP, RUN: begin
               if (ss_i) begin
                  state    <= IDLE;
                  busy_o   <= 1'b0;
                  sclk_o   <= cpol_q;
                  edge_cnt <= '0;
               end else if (tick && state == SETUP) begin
                  state <= RUN;
               end else if (tick) begin
                  sclk_o <= ~sclk_o;
                  if (edge_cnt == last_edge) begin
                     state    <= DONE;
                     done_o   <= 1'b1;
                     edge_cnt <= '0;
                  end else begin
                     edge_cnt <= edge_cnt + ECW'(1);
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               done_o <= 1'b0;
               busy_o <= 1'b0;
               sclk_o <= cpol_i;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Self-checking bench for spi_sclk_engine: a per-cycle expected trace is built from
// the half-period/edge rules by counting enabled cycles, then compared cycle by cycle.
module tb_spi_sclk_engine;

   logic        pclk = 1'b0;
   logic        preset_n;
   logic [1:0]  spi_mode_i;
   logic        spiswai_i;
   logic [2:0]  sppr_i;
   logic [2:0]  spr_i;
   logic        cpol_i;
   logic        cpha_i;
   logic        ss_i;
   logic [3:0]  len_i;
   logic        start_i;
   logic        sclk_o;
   logic        sample_o;
   logic        shift_o;
   logic        busy_o;
   logic        done_o;
   logic [11:0] brd_o;

   int checks   = 0;
   int failures = 0;

   // Expected per-cycle word {busy, done, sclk, sample, shift}
   logic [4:0] exp_q[$];

   spi_sclk_engine dut (
      .pclk       (pclk),
      .preset_n   (preset_n),
      .spi_mode_i (spi_mode_i),
      .spiswai_i  (spiswai_i),
      .sppr_i     (sppr_i),
      .spr_i      (spr_i),
      .cpol_i     (cpol_i),
      .cpha_i     (cpha_i),
      .ss_i       (ss_i),
      .len_i      (len_i),
      .start_i    (start_i),
      .sclk_o     (sclk_o),
      .sample_o   (sample_o),
      .shift_o    (shift_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .brd_o      (brd_o)
   );

   always #5 pclk = ~pclk;

   initial begin
      #900000;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic brd_check(input logic [2:0] pp, input logic [2:0] sp);
      @(posedge pclk); #1;
      sppr_i = pp;
      spr_i  = sp;
      @(posedge pclk);
      @(negedge pclk);
      check("brd", 32'(brd_o), (int'(pp) + 1) << (int'(sp) + 1));
   endtask

   // Offsets count cycles after the one in which start_i is driven.
   task automatic run_xfer(input logic cp, input logic ph, input logic [3:0] ln,
                           input logic [2:0] pp, input logic [2:0] sp,
                           input int fz_off, input int fz_len, input logic [1:0] fz_mode,
                           input logic fz_sw, input int ab_off, input int dup_off,
                           output int done_seen, output int n_samp, output int n_shf);
      int bits, h, cnt_en, o, k, done_exp, dup;
      logic lvl, samp, shf, tog, en, aborted;
      logic [4:0] obs;
      logic [4:0] exp;
      bits = (ln == 0 || ln > 8) ? 8 : int'(ln);
      h = (int'(pp) + 1) << sp;
      exp_q.delete();
      lvl = cp; cnt_en = 0; done_exp = 0; o = 1; aborted = 1'b0;
      while (done_exp == 0 && !aborted && o < 4000) begin
         if (ab_off > 0 && o == ab_off) begin
            exp_q.push_back({1'b1, 1'b0, lvl, 2'b00});
            aborted = 1'b1;
         end else begin
            en = !(o >= fz_off && o < fz_off + fz_len &&
                   (fz_mode[1] || (fz_mode == 2'b01 && fz_sw)));
            samp = 1'b0; shf = 1'b0; tog = 1'b0;
            if (en) begin
               cnt_en++;
               if (cnt_en % h == 0 && cnt_en / h >= 2) begin
                  k = cnt_en / h - 1;
                  if (!ph) begin
                     samp = (k % 2 == 1);
                     shf  = (k % 2 == 0) && (k != 2 * bits);
                  end else begin
                     shf  = (k % 2 == 1);
                     samp = (k % 2 == 0);
                  end
                  tog = 1'b1;
                  if (k == 2 * bits) done_exp = o + 1;
               end
            end
            exp_q.push_back({1'b1, 1'b0, lvl, samp, shf});
            if (tog) lvl = ~lvl;
            o++;
         end
      end
      if (!aborted) exp_q.push_back({1'b1, 1'b1, lvl, 2'b00});
      exp_q.push_back({1'b0, 1'b0, cp, 2'b00});
      dup = (dup_off < 0) ? int'($urandom_range(1, exp_q.size() - 1)) : dup_off;

      @(posedge pclk); #1;
      cpol_i = cp; cpha_i = ph; len_i = ln; sppr_i = pp; spr_i = sp;
      ss_i = 1'b0; spi_mode_i = 2'b00; spiswai_i = 1'b0; start_i = 1'b0;
      @(posedge pclk); #1;
      start_i = 1'b1;
      @(negedge pclk);
      check("idle_lvl", 32'(sclk_o), 32'(cp));
      check("idle_busy", 32'(busy_o), 0);

      done_seen = 0; n_samp = 0; n_shf = 0; o = 1;
      while (exp_q.size() > 0) begin
         @(posedge pclk); #1;
         start_i = (o == dup);
         ss_i = (ab_off > 0 && o >= ab_off);
         if (o >= fz_off && o < fz_off + fz_len) begin
            spi_mode_i = fz_mode; spiswai_i = fz_sw;
         end else begin
            spi_mode_i = 2'b00; spiswai_i = 1'b0;
         end
         if (o == 2) begin
            sppr_i = 3'($urandom_range(0, 7));
            spr_i  = 3'($urandom_range(0, 7));
            cpha_i = 1'($urandom_range(0, 1));
            len_i  = 4'($urandom_range(0, 15));
         end
         @(negedge pclk);
         obs = {busy_o, done_o, sclk_o, sample_o, shift_o};
         exp = exp_q.pop_front();
         check($sformatf("cyc%0d", o), 32'(obs), 32'(exp));
         if (done_o && done_seen == 0) done_seen = o;
         if (sample_o) n_samp++;
         if (shift_o) n_shf++;
         o++;
      end
      check("brd_live", 32'(brd_o), (int'(sppr_i) + 1) << (int'(spr_i) + 1));
      @(posedge pclk); #1;
      start_i = 1'b0; ss_i = 1'b0; spi_mode_i = 2'b00; spiswai_i = 1'b0;
   endtask

   initial begin
      int ds, ns, nf, base;
      preset_n = 1'b0; spi_mode_i = 2'b00; spiswai_i = 1'b0; sppr_i = 3'd0; spr_i = 3'd0;
      cpol_i = 1'b0; cpha_i = 1'b0; ss_i = 1'b0; len_i = 4'd0; start_i = 1'b0;
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      check("rst_sclk", 32'(sclk_o), 0);
      check("rst_brd", 32'(brd_o), 0);
      check("rst_sample", 32'(sample_o), 0);
      check("rst_shift", 32'(shift_o), 0);
      check("rst_busy", 32'(busy_o), 0);
      check("rst_done", 32'(done_o), 0);
      @(posedge pclk); #1;
      preset_n = 1'b1;

      brd_check(3'd0, 3'd1);
      brd_check(3'd7, 3'd7);
      for (int i = 0; i < 4; i++) brd_check(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

      // Reference transfer: H=2, 8 bits
      run_xfer(1'b0, 1'b0, 4'd8, 3'd0, 3'd1, 0, 0, 2'b00, 1'b0, 0, 0, ds, ns, nf);
      check("ref_done", 32'(ds), 35);
      check("ref_samples", 32'(ns), 8);
      check("ref_shifts", 32'(nf), 7);
      base = ds;

      for (int m = 0; m < 4; m++) begin
         run_xfer(1'(m >> 1), 1'(m), 4'd3, 3'd0, 3'd0, 0, 0, 2'b00, 1'b0, 0, 0, ds, ns, nf);
         check("m_samples", 32'(ns), 3);
         check("m_shifts", 32'(nf), (m % 2 == 1) ? 3 : 2);
         check("m_done", 32'(ds), 8);
      end

      run_xfer(1'b0, 1'b0, 4'd8, 3'd0, 3'd1, 10, 10, 2'b01, 1'b1, 0, 0, ds, ns, nf);
      check("wait_frozen_done", 32'(ds), 32'(base + 10));
      run_xfer(1'b0, 1'b0, 4'd8, 3'd0, 3'd1, 10, 10, 2'b01, 1'b0, 0, 0, ds, ns, nf);
      check("wait_run_done", 32'(ds), 32'(base));
      run_xfer(1'b1, 1'b1, 4'd5, 3'd1, 3'd0, 6, 7, 2'b10, 1'b0, 0, 0, ds, ns, nf);

      // Fifth edge strobes at offset 12 and is visible at 13.
      run_xfer(1'b1, 1'b0, 4'd8, 3'd0, 3'd1, 0, 0, 2'b00, 1'b0, 13, 0, ds, ns, nf);
      check("abort_no_done", 32'(ds), 0);
      run_xfer(1'b1, 1'b0, 4'd8, 3'd0, 3'd1, 0, 0, 2'b00, 1'b0, 0, 0, ds, ns, nf);
      check("post_abort_done", 32'(ds), 35);
      check("post_abort_samples", 32'(ns), 8);

      run_xfer(1'b0, 1'b0, 4'd0, 3'd0, 3'd0, 0, 0, 2'b00, 1'b0, 0, 0, ds, ns, nf);
      check("len0_samples", 32'(ns), 8);
      run_xfer(1'b0, 1'b0, 4'd1, 3'd0, 3'd0, 0, 0, 2'b00, 1'b0, 0, 0, ds, ns, nf);
      check("len1_samples", 32'(ns), 1);
      check("len1_shifts", 32'(nf), 0);
      check("len1_done", 32'(ds), 4);
      run_xfer(1'b0, 1'b1, 4'd8, 3'd0, 3'd1, 0, 0, 2'b00, 1'b0, 0, 9, ds, ns, nf);
      check("dup_start_done", 32'(ds), 35);

      for (int r = 0; r < 8; r++) begin
         run_xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 3'($urandom_range(0, 2)),
                  3'($urandom_range(0, 2)), int'($urandom_range(1, 20)),
                  int'($urandom_range(0, 8)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : 0,
                  -1, ds, ns, nf);
      end

      // Reset in the middle of a transfer
      @(posedge pclk); #1;
      cpol_i = 1'b1; cpha_i = 1'b0; len_i = 4'd8; sppr_i = 3'd0; spr_i = 3'd1;
      @(posedge pclk); #1;
      start_i = 1'b1;
      @(posedge pclk); #1;
      start_i = 1'b0;
      repeat (8) @(posedge pclk);
      #1;
      preset_n = 1'b0;
      @(posedge pclk);
      @(negedge pclk);
      check("mid_rst_sclk", 32'(sclk_o), 0);
      check("mid_rst_brd", 32'(brd_o), 0);
      check("mid_rst_busy", 32'(busy_o), 0);
      check("mid_rst_strobes", 32'({sample_o, shift_o, done_o}), 0);
      @(posedge pclk); #1;
      preset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge pclk);
         check("post_rst_done", 32'({busy_o, done_o}), 0);
      end
      check("post_rst_idle_lvl", 32'(sclk_o), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_sclk_engine.md
Name: spi_sclk_engine

Overview:
- Parametrised successor to the SPI baud-rate generator in the APB SPI controller.
- Computes the baud-rate divisor from generic-width SPPR/SPR fields and generates SCLK in all four CPOL/CPHA modes.
- Sequences one complete transfer of 1..MAX_BITS bits with a start/busy/done handshake, then emits per-edge sample/shift strobes to the shift register.
- Adds four behaviours the fixed-width generator lacks: a setup half-period, transfer length counting, freeze/resume under wait/stop modes, and abort on slave-select release.

Parameters:
PRE_W, 3, width of sppr_i (preselect)
SEL_W, 3, width of spr_i (select)
MAX_BITS, 8, maximum bits per transfer (>=1)
LEN_W, $clog2(MAX_BITS)+1, width of len_i
BRD_W, PRE_W+1+2**SEL_W, width of brd_o (12 at defaults)

Ports:
pclk  in  1  system clock, sole clock
preset_n  in  1  synchronous, active-low reset
spi_mode_i  in  2  00 run, 01 wait, 10/11 stop
spiswai_i  in  1  1 = stop SCLK in wait mode
sppr_i  in  PRE_W  baud preselect
spr_i  in  SEL_W  baud select
cpol_i  in  1  clock polarity
cpha_i  in  1  clock phase
ss_i  in  1  slave select, active low
len_i  in  LEN_W  bits per transfer
start_i  in  1  one-cycle start request
sclk_o  out  1  serial clock
sample_o  out  1  MISO sample strobe
shift_o  out  1  MOSI shift strobe
busy_o  out  1  transfer in progress
done_o  out  1  one-cycle completion pulse
brd_o  out  BRD_W  baud-rate divisor

Behaviour:
- All state updates on the rising edge of pclk. Reset is synchronous and active-low on preset_n.
- Reset values: sclk_o=0, brd_o=0, sample_o=shift_o=busy_o=done_o=0, FSM=IDLE, counters=0.
- brd_o is registered each cycle from the live inputs: (sppr_i+1) << (spr_i+1). Latency is 1 cycle.
- Half-period H = (sppr+1) << spr pclk cycles. Minimum H is 1.
- Launch: at start, sppr, spr, cpol, cpha and len are latched. Effective bits = len, except len=0 or len>MAX_BITS is clamped to MAX_BITS.
- en = (mode==00) or (mode==01 and !spiswai_i).
- Tick counter:
  - Runs only in SETUP/RUN with en=1.
  - Counts 0..H-1. At H-1 it wraps to 0 and raises an event.
- FSM IDLE:
  - sclk_o <= cpol_i (live).
  - start_i=1 and ss_i=0 -> SETUP.
  - start_i with ss_i=1 is ignored.
  - start_i while not IDLE is ignored.
- FSM SETUP: event -> RUN. No toggle. This gives one half-period of data setup.
- FSM RUN:
  - On each event: sclk_o toggles and edge_cnt increments.
  - Event at edge_cnt = 2*bits-1 -> DONE.
- FSM DONE: done_o=1 for this single cycle, then -> IDLE. sclk_o equals latched cpol here.
- busy_o = 1 in SETUP, RUN and DONE.
- Strobes are high only in the cycle of a RUN event, i.e. the cycle before sclk_o changes.
- Edge numbering k = 1..2*bits, where k=1 is the leading edge.
- cpha=0:
  - sample_o on odd k.
  - shift_o on even k, except k=2*bits (no pulse).
- cpha=1:
  - shift_o on odd k.
  - sample_o on even k.
- sample_o and shift_o are never both high.
- Freeze (en=0 during SETUP/RUN): counter, edge_cnt and sclk_o hold, and no strobes are issued. Execution resumes exactly where it stopped when en returns to 1.
- Abort: ss_i=1 during SETUP/RUN -> IDLE next cycle. sclk_o returns to cpol, there is no done_o, and counters clear.
- Simultaneous events:
  - Abort beats event.
  - Freeze beats event.
- Mid-transfer changes to sppr/spr/cpol/cpha/len affect brd_o only. The active transfer keeps its latched values.
- Reset mid-transfer: outputs go to reset values at the next edge, and no done_o is issued.

Decomposition:
- Shared package spi_pkg holds:
  - mode encodings (SPI_RUN, SPI_WAIT, SPI_STOP)
  - FSM state enum (IDLE, SETUP, RUN, DONE)
  - a divisor-width helper function
- One sub-module, spi_tick_counter: the H computation plus wrap counter with enable/clear, emitting a one-cycle event.

Test Plan:
1. Reset, then sppr=0, spr=1 -> brd_o=4 one cycle later. Then sppr=7, spr=7 -> brd_o=2048.
2. cpol=0, cpha=0, len=8, sppr=0, spr=1 (H=2), start at cycle T:
   - busy_o rises at T+1.
   - First sclk rise is visible at T+5.
   - There are 8 sample_o pulses and 7 shift_o pulses.
   - done_o is high at T+35 only.
   - sclk_o ends at 0.
3. All four CPOL/CPHA modes with len=3, H=1 -> idle level equals cpol. Exactly 6 toggles. Strobe placement per the parity rules above.
4. Wait-freeze: spi_mode=01 and spiswai=1 asserted for 10 cycles mid-RUN -> sclk_o and the strobes hold. Completion is delayed by exactly 10 cycles. Repeating with spiswai=0 gives no delay.
5. Abort: ss_i raised after edge 5 -> next cycle busy_o=0 and sclk_o=cpol, with no done_o. A fresh start then runs a full 16-edge transfer.
6. Boundaries:
   - len=0 -> 8 bits.
   - len=1 -> 2 edges and 1 sample.
   - start_i during busy -> ignored.
   - preset_n low mid-RUN -> all outputs 0 next cycle.
